// File: rtl/e203_exu_eai_csr_bridge.sv
// EAI CSR bridge: turns each held-stable EAI CSR access into a registered
// request/response transaction to an external coprocessor. It also enforces
// a response timeout, rejects out-of-range addresses and drains late
// responses that arrive after a timeout.
module e203_exu_eai_csr_bridge #(
  parameter int TMO_CYC = 256,
  parameter int CNT_W   = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        eai_csr_valid,
  output logic        eai_csr_ready,
  input  logic [31:0] eai_csr_addr,
  input  logic        eai_csr_wr,
  input  logic [31:0] eai_csr_wdata,
  output logic [31:0] eai_csr_rdata,
  output logic        eai_csr_err,
  output logic        eai_xs_off,
  input  logic        cop_present,
  output logic        cop_req_valid,
  input  logic        cop_req_ready,
  output logic [11:0] cop_req_addr,
  output logic        cop_req_wr,
  output logic [31:0] cop_req_wdata,
  input  logic        cop_rsp_valid,
  output logic        cop_rsp_ready,
  input  logic [31:0] cop_rsp_rdata,
  input  logic        cop_rsp_err,
  output logic        tmo_sticky,
  input  logic        tmo_clr
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // The counter can step one past the limit when the request handshakes on
  // the last allowed cycle, so the limit is compared with >=.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_CYC - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              stale_q, stale_d;
  logic              sticky_q, sticky_d;
  logic [11:0]       addr_q, addr_d;
  logic              wr_q, wr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              req_valid_q, req_valid_d;
  logic              rsp_ready_q, rsp_ready_d;
  logic              csr_ready_q, csr_ready_d;
  logic [31:0]       csr_rdata_q, csr_rdata_d;
  logic              csr_err_q, csr_err_d;
  logic              xs_off_q;
  logic              tmo_set;
  logic              stale_set;
  logic              tmo_hit;

  assign tmo_hit = (cnt_q >= TMO_LAST);

  // Next-state, capture, timeout and stale-drain logic; outputs are
  // precomputed from the next state so they can be registered.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stale_d   = stale_q;
    sticky_d  = sticky_q;
    addr_d    = addr_q;
    wr_d      = wr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    tmo_set   = 1'b0;
    stale_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (eai_csr_valid && !stale_q) begin
          addr_d  = eai_csr_addr[11:0];
          wr_d    = eai_csr_wr;
          wdata_d = eai_csr_wdata;
          if ((eai_csr_addr[31:12] != 20'd0) || !cop_present) begin
            rdata_d = 32'd0;
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            cnt_d   = '0;
            state_d = ST_REQ;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cop_req_ready) begin
          state_d = ST_RSP;
        end else if (tmo_hit) begin
          rdata_d = 32'd0;
          err_d   = 1'b1;
          tmo_set = 1'b1;
          state_d = ST_DONE;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_RSP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cop_rsp_valid) begin
          rdata_d = wr_q ? 32'd0 : cop_rsp_rdata;
          err_d   = cop_rsp_err;
          state_d = ST_DONE;
        end else if (tmo_hit) begin
          rdata_d   = 32'd0;
          err_d     = 1'b1;
          tmo_set   = 1'b1;
          stale_set = 1'b1;
          state_d   = ST_DONE;
        end else begin
          state_d = ST_RSP;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A late response accepted outside RSP is dropped and ends the drain.
    if ((state_q != ST_RSP) && stale_q && cop_rsp_valid) begin
      stale_d = 1'b0;
    end else if (stale_set) begin
      stale_d = 1'b1;
    end else begin
      stale_d = stale_q;
    end

    // tmo_clr beats a same-cycle timeout.
    if (tmo_clr) begin
      stale_d  = 1'b0;
      sticky_d = 1'b0;
    end else if (tmo_set) begin
      sticky_d = 1'b1;
    end else begin
      sticky_d = sticky_q;
    end

    req_valid_d = (state_d == ST_REQ);
    rsp_ready_d = (state_d == ST_RSP) || stale_d;
    csr_ready_d = (state_d == ST_DONE);
    csr_rdata_d = csr_ready_d ? rdata_d : 32'd0;
    csr_err_d   = csr_ready_d ? err_d : 1'b0;
  end

  // State, capture and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      stale_q     <= 1'b0;
      sticky_q    <= 1'b0;
      addr_q      <= 12'd0;
      wr_q        <= 1'b0;
      wdata_q     <= 32'd0;
      rdata_q     <= 32'd0;
      err_q       <= 1'b0;
      req_valid_q <= 1'b0;
      rsp_ready_q <= 1'b0;
      csr_ready_q <= 1'b0;
      csr_rdata_q <= 32'd0;
      csr_err_q   <= 1'b0;
      xs_off_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stale_q     <= stale_d;
      sticky_q    <= sticky_d;
      addr_q      <= addr_d;
      wr_q        <= wr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      req_valid_q <= req_valid_d;
      rsp_ready_q <= rsp_ready_d;
      csr_ready_q <= csr_ready_d;
      csr_rdata_q <= csr_rdata_d;
      csr_err_q   <= csr_err_d;
      xs_off_q    <= ~cop_present;
    end
  end

  assign eai_csr_ready = csr_ready_q;
  assign eai_csr_rdata = csr_rdata_q;
  assign eai_csr_err   = csr_err_q;
  assign eai_xs_off    = xs_off_q;
  assign cop_req_valid = req_valid_q;
  assign cop_req_addr  = addr_q;
  assign cop_req_wr    = wr_q;
  assign cop_req_wdata = wdata_q;
  assign cop_rsp_ready = rsp_ready_q;
  assign tmo_sticky    = sticky_q;

endmodule

// File: doc/e203_exu_eai_csr_bridge.md
Name: e203_exu_eai_csr_bridge

Overview:
- Sits downstream of the ALU CSR-control stage on its EAI CSR channel (eai_csr_valid/ready/addr/wr/wdata/rdata).
- Converts each held-stable EAI CSR access into a registered request/response transaction to an external coprocessor.
- Enforces a response timeout, rejects out-of-range addresses, and reports errors.
- Returns read data to the CSR-control stage with a single-cycle ready pulse.

Parameters:
TMO_CYC, 256, cycles allowed from entering REQ until a response is accepted before timing out (>=2)
CNT_W, 9, timeout counter width; must hold TMO_CYC

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
eai_csr_valid  in  1  CSR access request; held stable with its payload until eai_csr_ready
eai_csr_ready  out  1  one-cycle completion pulse
eai_csr_addr  in  32  CSR address
eai_csr_wr  in  1  1=write, 0=read
eai_csr_wdata  in  32  write data
eai_csr_rdata  out  32  read data, valid only with eai_csr_ready
eai_csr_err  out  1  error flag, valid only with eai_csr_ready
eai_xs_off  out  1  registered ~cop_present
cop_present  in  1  coprocessor attached and enabled
cop_req_valid  out  1  request to coprocessor
cop_req_ready  in  1  coprocessor accepts request
cop_req_addr  out  12  captured eai_csr_addr[11:0]
cop_req_wr  out  1  captured eai_csr_wr
cop_req_wdata  out  32  captured eai_csr_wdata
cop_rsp_valid  in  1  response from coprocessor
cop_rsp_ready  out  1  response accept
cop_rsp_rdata  in  32  response data
cop_rsp_err  in  1  response error
tmo_sticky  out  1  set on any timeout; cleared by tmo_clr
tmo_clr  in  1  clears tmo_sticky and the stale flag

Behaviour:
- Reset: the only reset is synchronous active-low rst_n on clk.
  - State goes to IDLE.
  - All outputs are 0, except eai_xs_off, which becomes 1 on the first clock after reset.
  - The counter, stale flag and tmo_sticky are cleared.
  - Reset during any state aborts the transaction and drops cop_req_valid the next cycle; the bridge does not wait for the coprocessor.
- States: IDLE, REQ, RSP, DONE. Encoding is free.
- IDLE, when eai_csr_valid=1 and stale=0:
  - Capture addr[11:0], wr and wdata.
  - If eai_csr_addr[31:12]!=0 or cop_present=0: load rdata=0, err=1 and go to DONE. No coprocessor request is made.
  - Otherwise clear the counter and go to REQ.
- IDLE, when stale=1: the request waits; eai_csr_ready stays 0.
- REQ:
  - cop_req_valid=1; cop_req_addr/wr/wdata come from the capture registers and are stable.
  - On cop_req_ready=1, go to RSP.
- RSP:
  - cop_rsp_ready=1.
  - On cop_rsp_valid=1: capture rdata=cop_rsp_rdata and err=cop_rsp_err, then go to DONE.
  - For reads, rdata is passed through. For writes, rdata is forced to 0.
- Timeout counter:
  - Increments every cycle in REQ and RSP.
  - When it reaches TMO_CYC-1 with no handshake that cycle: rdata=0, err=1, tmo_sticky=1, go to DONE.
  - If the timeout is in RSP, also set stale=1.
  - A handshake in the same cycle as the timeout wins; no timeout is recorded.
- DONE:
  - eai_csr_ready=1 for exactly one cycle, with eai_csr_rdata and eai_csr_err from the capture registers.
  - Always go to IDLE next.
  - eai_csr_rdata/err are 0 whenever eai_csr_ready=0.
- Stale drain:
  - Outside RSP, cop_rsp_ready=stale.
  - A response accepted while stale=1 is discarded and clears stale.
  - tmo_clr=1 clears stale and tmo_sticky; tmo_clr has priority over a same-cycle timeout set.
- Throughput:
  - Minimum latency is 3 cycles from eai_csr_valid (seen in IDLE) to eai_csr_ready: IDLE, REQ (ready=1), RSP (rsp=1), DONE.
  - Rejected accesses take 1 cycle (IDLE, DONE).
  - A new request may arrive the cycle after DONE.
- eai_xs_off: registered ~cop_present, one-cycle delay. A cop_present change mid-transaction does not abort it.

Test Plan:
- Read: addr=0x7C0, wr=0, cop_req_ready=1 immediately, cop_rsp_valid next cycle with rdata=0xDEADBEEF, err=0 -> eai_csr_ready pulses on cycle 3; rdata=0xDEADBEEF, err=0; cop_req_addr=0x7C0.
- Write with backpressure: wr=1, wdata=0x12345678, cop_req_ready held 0 for 5 cycles -> cop_req_valid/addr/wdata stable throughout; on response eai_csr_rdata=0, err=cop_rsp_err.
- Rejects: addr=0x0001_07C0 -> ready on cycle 1 with err=1, rdata=0, and cop_req_valid never asserted; same outcome with cop_present=0 (also eai_xs_off=1).
- Timeout: TMO_CYC=8, request accepted but no response -> ready with err=1 at counter=7, tmo_sticky=1, stale=1.
  - Next request waits in IDLE.
  - A late cop_rsp_valid is consumed and discarded; the next request then proceeds.
  - Repeat using tmo_clr instead of the late response to release the wait.
- Boundaries: response arriving exactly at counter=TMO_CYC-1 -> normal completion and tmo_sticky stays 0. rst_n=0 asserted in RSP -> next cycle IDLE, all outputs 0, and no eai_csr_ready pulse.
